// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: issues sequential word-aligned fetches under a
// credit limit, buffers returned words with their PCs in a small FIFO and hands
// them to the decoder over valid/ready. A redirect flushes the FIFO, restarts
// fetch at the new PC and retires in-flight stale responses without pushing them.
module inst_fetch_queue #(
    parameter int unsigned      cXLEN    = 32,
    parameter int unsigned      cInstW   = 32,
    parameter int unsigned      cDepth   = 4,
    parameter logic [cXLEN-1:0] cResetPc = '0
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iRedirect,
    input  logic [cXLEN-1:0]  iRedirectPc,
    output logic              oMemReqValid,
    output logic [cXLEN-1:0]  oMemReqAddr,
    input  logic              iMemReqReady,
    input  logic              iMemRspValid,
    input  logic [cInstW-1:0] iMemRspData,
    output logic              oInstValid,
    output logic [cInstW-1:0] oInst,
    output logic [cXLEN-1:0]  oInstPc,
    input  logic              iInstReady
);

    localparam int unsigned      cPtrW      = $clog2(cDepth);
    localparam int unsigned      cCntW      = cPtrW + 1;
    localparam logic [cCntW-1:0] cFull      = cCntW'(cDepth);
    localparam logic [cCntW:0]   cCredit    = (cCntW + 1)'(cDepth);
    localparam logic [cXLEN-1:0] cPcStep    = cXLEN'(4);
    localparam logic [cXLEN-1:0] cAlignMask = ~cXLEN'(3);

    logic [cXLEN-1:0]  fetchPc_q, fetchPc_d;
    logic [cXLEN-1:0]  rspPc_q, rspPc_d;
    logic [cPtrW-1:0]  wrPtr_q, wrPtr_d;
    logic [cPtrW-1:0]  rdPtr_q, rdPtr_d;
    logic [cCntW-1:0]  count_q, count_d;
    logic [cCntW-1:0]  inFlight_q, inFlight_d;
    logic [cCntW-1:0]  dropCnt_q, dropCnt_d;

    logic [cInstW-1:0] instMem_q [cDepth];
    logic [cXLEN-1:0]  pcMem_q   [cDepth];

    logic [cCntW:0]    outstanding;
    logic              credit;
    logic              reqAccept;
    logic              rspPush;
    logic              rspDrop;
    logic              pop;
    logic              empty;
    logic              full;
    logic [cXLEN-1:0]  redirPc;
    logic [cCntW-1:0]  redirDrop;

    // Handshake decode and output presentation.
    always_comb begin
        outstanding  = {1'b0, count_q} + {1'b0, inFlight_q};
        credit       = outstanding < cCredit;
        oMemReqValid = !iRst && !iRedirect && credit;
        oMemReqAddr  = fetchPc_q & cAlignMask;
        reqAccept    = oMemReqValid && iMemReqReady;
        empty        = (count_q == '0);
        full         = (count_q == cFull);
        oInstValid   = !empty;
        pop          = oInstValid && iInstReady;
        rspPush      = iMemRspValid && (dropCnt_q == '0);
        rspDrop      = iMemRspValid && (dropCnt_q != '0);
        oInst        = empty ? '0 : instMem_q[rdPtr_q];
        oInstPc      = empty ? '0 : pcMem_q[rdPtr_q];
        redirPc      = iRedirectPc & cAlignMask;
        // A response landing in the redirect cycle is already stale and retires now.
        redirDrop    = inFlight_q - cCntW'(iMemRspValid);
    end

    // Next-state for PCs, FIFO pointers and the in-flight/drop counters.
    always_comb begin
        fetchPc_d  = fetchPc_q;
        rspPc_d    = rspPc_q;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        inFlight_d = inFlight_q;
        dropCnt_d  = dropCnt_q;

        if (iRedirect) begin
            fetchPc_d  = redirPc;
            rspPc_d    = redirPc;
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            count_d    = '0;
            dropCnt_d  = redirDrop;
            inFlight_d = redirDrop;
        end else begin
            if (reqAccept) begin
                fetchPc_d = fetchPc_q + cPcStep;
            end

            case ({reqAccept, iMemRspValid})
                2'b10:   inFlight_d = inFlight_q + cCntW'(1);
                2'b01:   inFlight_d = inFlight_q - cCntW'(1);
                default: inFlight_d = inFlight_q;
            endcase

            if (rspDrop) begin
                dropCnt_d = dropCnt_q - cCntW'(1);
            end

            if (rspPush) begin
                wrPtr_d = wrPtr_q + cPtrW'(1);
                rspPc_d = rspPc_q + cPcStep;
            end

            if (pop) begin
                rdPtr_d = rdPtr_q + cPtrW'(1);
            end

            case ({rspPush, pop})
                2'b10:   count_d = count_q + cCntW'(1);
                2'b01:   count_d = count_q - cCntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            fetchPc_q  <= cResetPc;
            rspPc_q    <= cResetPc;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            inFlight_q <= '0;
            dropCnt_q  <= '0;
        end else begin
            fetchPc_q  <= fetchPc_d;
            rspPc_q    <= rspPc_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            inFlight_q <= inFlight_d;
            dropCnt_q  <= dropCnt_d;
        end
    end

    // FIFO storage; contents need no reset since count_q gates visibility.
    always_ff @(posedge iClk) begin
        if (!iRst && !iRedirect && rspPush) begin
            instMem_q[wrPtr_q] <= iMemRspData;
            pcMem_q[wrPtr_q]   <= rspPc_q;
        end
    end

    // Overflow guard: the credit rule must always leave a slot for each response.
    always_ff @(posedge iClk) begin
        if (!iRst && !iRedirect) begin
            assert (!(rspPush && full))
                else $fatal(1, "inst_fetch_queue: response pushed into full queue");
        end
    end

endmodule
